// File: rtl/instr_buffer_pkg.sv
// Shared sizing and record layout for the instruction buffer between IF1 and decode.
package instr_buffer_pkg;

    localparam int IB_DEPTH      = 16;  // entries, power of two
    localparam int IB_DEPTH_LOG2 = 4;   // log2(IB_DEPTH)
    localparam int IB_DATA_WD    = 66;  // one fetched record
    localparam int IB_PUSH_SLOTS = 4;   // records IF1 can deliver per cycle
    localparam int IB_POP_SLOTS  = 2;   // records decode can consume per cycle

    // Record layout, MSB first: {pc_valid, pc_is_jump, pc, instr}
    typedef struct packed {
        logic        pc_valid;
        logic        pc_is_jump;
        logic [31:0] pc;
        logic [31:0] instr;
    } ib_rec_t;

endpackage

// File: rtl/ib_regfile.sv
// Instruction buffer storage: DEPTH x DATA_WD flops, four write ports, two async read ports.
module ib_regfile
    import instr_buffer_pkg::*;
#(
    parameter int DEPTH      = IB_DEPTH,
    parameter int DEPTH_LOG2 = IB_DEPTH_LOG2,
    parameter int DATA_WD    = IB_DATA_WD
) (
    input  logic                               clk,
    input  logic [IB_PUSH_SLOTS-1:0]           wen,
    input  logic [IB_PUSH_SLOTS*DEPTH_LOG2-1:0] waddr,
    input  logic [IB_PUSH_SLOTS*DATA_WD-1:0]   wdata,
    input  logic [DEPTH_LOG2-1:0]              raddr0,
    input  logic [DEPTH_LOG2-1:0]              raddr1,
    output logic [DATA_WD-1:0]                 rdata0,
    output logic [DATA_WD-1:0]                 rdata1
);

    logic [DATA_WD-1:0] mem [DEPTH];

    // Write every enabled slot; the pointer logic guarantees distinct addresses per cycle.
    // NOTE: storage is not reset; an entry is only read once head/count mark it occupied.
    always_ff @(posedge clk) begin
        for (int k = 0; k < IB_PUSH_SLOTS; k++) begin
            if (wen[k]) begin
                mem[waddr[k*DEPTH_LOG2 +: DEPTH_LOG2]] <= wdata[k*DATA_WD +: DATA_WD];
            end
        end
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/instr_buffer.sv
// Circular instruction buffer: up to 4 pushes from IF1, up to 2 pops to the dual-issue decoder.
module instr_buffer
    import instr_buffer_pkg::*;
#(
    parameter int DEPTH      = IB_DEPTH,
    parameter int DEPTH_LOG2 = IB_DEPTH_LOG2,
    parameter int DATA_WD    = IB_DATA_WD
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush_IB,
    input  logic [IB_PUSH_SLOTS*DATA_WD-1:0] if1_to_ib,
    input  logic [2:0]                      push_num,
    output logic [DEPTH_LOG2:0]             can_push_size,
    output logic [IB_POP_SLOTS*DATA_WD-1:0] ib_to_id,
    output logic [1:0]                      ib_valid,
    input  logic [1:0]                      id_pop_num
);

    localparam int                CNT_W    = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0]  MAX_FILL = CNT_W'(DEPTH - 1);

    logic [DEPTH_LOG2-1:0]               head;
    logic [DEPTH_LOG2-1:0]               tail;
    logic [CNT_W-1:0]                    count;
    logic [CNT_W-1:0]                    free_slots;
    logic                                clear;
    logic                                push_ok;
    logic [2:0]                          acc_push;
    logic [1:0]                          pop_req;
    logic [1:0]                          eff_pop;
    logic [IB_PUSH_SLOTS-1:0]            wen;
    logic [IB_PUSH_SLOTS*DEPTH_LOG2-1:0] waddr;
    logic [DATA_WD-1:0]                  rdata0;
    logic [DATA_WD-1:0]                  rdata1;

    assign clear = !rst || flush_IB;

    // Accepted push size (whole group dropped if it would exceed DEPTH-1) and clamped pop size.
    always_comb begin
        free_slots = MAX_FILL - count;
        push_ok    = (push_num <= 3'(IB_PUSH_SLOTS)) && (CNT_W'(push_num) <= free_slots);
        acc_push   = push_ok ? push_num : 3'd0;
        pop_req    = (id_pop_num > 2'(IB_POP_SLOTS)) ? 2'(IB_POP_SLOTS) : id_pop_num;
        eff_pop    = (count < CNT_W'(pop_req)) ? count[1:0] : pop_req;
    end

    // Write-port addressing: slot k lands at tail+k, wrapping modulo DEPTH.
    // NOTE: every signal gets a default before the loop so no path can infer a latch.
    always_comb begin
        wen   = '0;
        waddr = '0;
        for (int k = 0; k < IB_PUSH_SLOTS; k++) begin
            wen[k]                            = !clear && (3'(k) < acc_push);
            waddr[k*DEPTH_LOG2 +: DEPTH_LOG2] = tail + DEPTH_LOG2'(k);
        end
    end

    // Pointer and occupancy update; reset and flush both empty the buffer and ignore push/pop.
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + DEPTH_LOG2'(eff_pop);
            tail  <= tail + DEPTH_LOG2'(acc_push);
            count <= count + CNT_W'(acc_push) - CNT_W'(eff_pop);
        end
    end

    ib_regfile #(
        .DEPTH      (DEPTH),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_WD    (DATA_WD)
    ) u_rf (
        .clk    (clk),
        .wen    (wen),
        .waddr  (waddr),
        .wdata  (if1_to_ib),
        .raddr0 (head),
        .raddr1 (head + DEPTH_LOG2'(1)),
        .rdata0 (rdata0),
        .rdata1 (rdata1)
    );

    assign can_push_size = count;
    assign ib_to_id      = {rdata1, rdata0};
    assign ib_valid      = {count >= CNT_W'(2), count >= CNT_W'(1)};

endmodule

// File: tb/tb_instr_buffer.sv
// Scoreboard bench for instr_buffer: queue of expected records, compared as decode sees them.
module tb_instr_buffer;
    import instr_buffer_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush_IB = 1'b0;
    logic [263:0]  if1_to_ib = '0;
    logic [2:0]    push_num = '0;
    logic [4:0]    can_push_size;
    logic [131:0]  ib_to_id;
    logic [1:0]    ib_valid;
    logic [1:0]    id_pop_num = '0;

    ib_rec_t stim [4];
    ib_rec_t q [$];
    int      n_cmp = 0;
    int      n_err = 0;

    instr_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .flush_IB      (flush_IB),
        .if1_to_ib     (if1_to_ib),
        .push_num      (push_num),
        .can_push_size (can_push_size),
        .ib_to_id      (ib_to_id),
        .ib_valid      (ib_valid),
        .id_pop_num    (id_pop_num)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ib_rec_t mk(input logic [31:0] pc);
        ib_rec_t r;
        r.pc_valid   = 1'($urandom_range(0, 1));
        r.pc_is_jump = 1'($urandom_range(0, 1));
        r.pc         = pc;
        r.instr      = $urandom;
        return r;
    endfunction

    task automatic set_stim(input logic [31:0] base);
        for (int k = 0; k < 4; k++) stim[k] = mk(base + 32'(4 * k));
    endtask

    // One clock: drive at negedge, compare visible outputs against the model, then advance the model.
    task automatic cycle(input int pnum, input int pop, input bit fl, input bit rs, input bit chk);
        int eff;
        @(negedge clk);
        rst        = rs;
        flush_IB   = fl;
        push_num   = 3'(pnum);
        id_pop_num = 2'(pop);
        if1_to_ib  = {stim[3], stim[2], stim[1], stim[0]};
        #1;
        if (rs && !fl && pnum > 0)
            check("push_legal", 66'(pnum <= 15 - q.size()), 66'(1));
        if (chk) begin
            check("count", 66'(can_push_size), 66'(q.size()));
            check("valid", 66'(ib_valid), 66'({q.size() >= 2, q.size() >= 1}));
            if (q.size() >= 1) check("slot0", ib_to_id[65:0], q[0]);
            if (q.size() >= 2) check("slot1", ib_to_id[131:66], q[1]);
        end
        @(posedge clk);
        if (!rs || fl) begin
            q.delete();
        end else begin
            eff = (pop > 2) ? 2 : pop;
            if (eff > q.size()) eff = q.size();
            repeat (eff) void'(q.pop_front());
            for (int k = 0; k < pnum; k++) q.push_back(stim[k]);
        end
    endtask

    initial begin
        int pn;
        int po;

        // Reset held for two cycles with a push pending.
        set_stim(32'h0bad_0000);
        cycle(4, 0, 0, 0, 0);
        cycle(4, 0, 0, 0, 1);
        #1;
        check("rst_count", 66'(can_push_size), 66'(0));
        check("rst_valid", 66'(ib_valid), 66'(0));
        cycle(0, 0, 0, 1, 1);

        // Basic push of three records.
        set_stim(32'h1c00_0000);
        cycle(3, 0, 0, 1, 1);
        #1;
        check("basic_count", 66'(can_push_size), 66'(3));
        check("basic_valid", 66'(ib_valid), 66'(2'b11));
        check("basic_pc0", 66'(ib_to_id[63:32]), 66'(32'h1c00_0000));
        check("basic_pc1", 66'(ib_to_id[129:98]), 66'(32'h1c00_0004));

        // Simultaneous push/pop at count 5.
        set_stim(32'h1c00_000c);
        cycle(2, 0, 0, 1, 1);
        set_stim(32'h1c00_0014);
        cycle(4, 2, 0, 1, 1);
        #1;
        check("pp_count", 66'(can_push_size), 66'(7));
        check("pp_pc0", 66'(ib_to_id[63:32]), 66'(32'h1c00_0008));
        repeat (4) cycle(0, 2, 0, 1, 1);

        // Wrap: head = tail = 14, then a 4-record push straddling the end.
        cycle(0, 0, 1, 1, 1);
        set_stim(32'h3000_0000);
        cycle(4, 0, 0, 1, 1);
        cycle(4, 0, 0, 1, 1);
        cycle(4, 0, 0, 1, 1);
        cycle(2, 0, 0, 1, 1);
        repeat (7) cycle(0, 2, 0, 1, 1);
        stim[0] = mk(32'h0000_00a0);
        stim[1] = mk(32'h0000_00b0);
        stim[2] = mk(32'h0000_00c0);
        stim[3] = mk(32'h0000_00d0);
        cycle(4, 0, 0, 1, 1);
        #1;
        check("wrap_idx14", dut.u_rf.mem[14], stim[0]);
        check("wrap_idx15", dut.u_rf.mem[15], stim[1]);
        check("wrap_idx0", dut.u_rf.mem[0], stim[2]);
        check("wrap_idx1", dut.u_rf.mem[1], stim[3]);
        cycle(0, 2, 0, 1, 1);
        cycle(0, 2, 0, 1, 1);
        cycle(0, 0, 0, 1, 1);

        // Fill to DEPTH-1, hold, drain, then over-pop at count 1.
        set_stim(32'h4000_0000);
        cycle(4, 0, 0, 1, 1);
        cycle(4, 0, 0, 1, 1);
        cycle(4, 0, 0, 1, 1);
        cycle(3, 0, 0, 1, 1);
        cycle(0, 0, 0, 1, 1);
        #1;
        check("full_count", 66'(can_push_size), 66'(15));
        repeat (7) cycle(0, 2, 0, 1, 1);
        cycle(0, 2, 0, 1, 1);
        #1;
        check("overpop_count", 66'(can_push_size), 66'(0));
        check("overpop_valid", 66'(ib_valid), 66'(0));
        cycle(0, 3, 0, 1, 1);

        // Flush mid-stream at count 9 with push and pop also requested.
        set_stim(32'h5000_0000);
        cycle(4, 0, 0, 1, 1);
        cycle(4, 0, 0, 1, 1);
        cycle(1, 0, 0, 1, 1);
        cycle(4, 2, 1, 1, 1);
        #1;
        check("flush_count", 66'(can_push_size), 66'(0));
        check("flush_valid", 66'(ib_valid), 66'(0));
        set_stim(32'h2000_0000);
        cycle(1, 0, 0, 1, 1);
        #1;
        check("flush_pc0", 66'(ib_to_id[63:32]), 66'(32'h2000_0000));

        // Random legal traffic with occasional flushes and over-pops.
        for (int i = 0; i < 300; i++) begin
            set_stim($urandom);
            pn = $urandom_range(0, 4);
            if (pn > 15 - q.size()) pn = 15 - q.size();
            po = $urandom_range(0, 3);
            cycle(pn, po, ($urandom_range(0, 31) == 0), 1, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
